// File: rtl/cdr_pi_ctrl.sv
// CDR loop controller: early/late vote integrator, wrapping PI code stepper, lock FSM.
// Define CDR_PI_GRAY_OUT_EN to present pi_code as registered Gray code.
module cdr_pi_ctrl #(
  parameter int CODE_W       = 6,
  parameter int THRESH       = 8,
  parameter int ACQ_STEP     = 4,
  parameter int ACQ_CYCLES   = 256,
  parameter int LOCK_WIN     = 64,
  parameter int LOCK_MAX_UPD = 2,
  parameter int LOCK_CNT     = 4,
  parameter int UNLOCK_UPD   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              dn,
  output logic [CODE_W-1:0] pi_code,
  output logic              pi_code_vld,
  output logic              locked,
  output logic              lol,
  output logic [1:0]        state
);

  localparam int IW = $clog2(THRESH) + 2;
  localparam int PW = $clog2(ACQ_CYCLES);
  localparam int WW = $clog2(LOCK_WIN);
  localparam int UW = $clog2(LOCK_WIN + 1);
  localparam int QW = $clog2(LOCK_CNT + 1);

  localparam logic signed [IW-1:0] THR_P = IW'(THRESH);
  localparam logic signed [IW-1:0] THR_N = -THR_P;
  localparam logic [UW-1:0] UMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_TRACK = 2'd2,
    S_LOCK  = 2'd3
  } st_t;

  st_t st_q, st_d;

  logic signed [IW-1:0] integ_q, integ_d;
  logic signed [IW-1:0] vote, sum;
  logic [CODE_W-1:0]    code_q, code_d, stp_sz;
  logic [PW-1:0]        ph_q, ph_d;
  logic [WW-1:0]        win_q, win_d;
  logic [UW-1:0]        upd_q, upd_d, upd_tot;
  logic [QW-1:0]        qt_q, qt_d, qt_nx;
  logic                 step_up, step_dn, stepped;
  logic                 win_end, vld_d, lol_d;

  always_comb begin
    vote = '0;
    if (up && !dn) vote = IW'(1);
    else if (dn && !up) vote = -IW'(1);
  end

  assign sum     = integ_q + vote;
  assign step_up = sum >= THR_P;
  assign step_dn = sum <= THR_N;
  assign stepped = step_up || step_dn;
  assign stp_sz  = (st_q == S_ACQ) ? CODE_W'(ACQ_STEP) : CODE_W'(1);
  assign win_end = win_q == WW'(LOCK_WIN - 1);
  // The update landing on the last window cycle still counts.
  assign upd_tot = (upd_q == UMAX) ? upd_q : upd_q + UW'(stepped);

  always_comb begin
    st_d    = st_q;
    integ_d = integ_q;
    code_d  = code_q;
    ph_d    = ph_q;
    win_d   = win_q;
    upd_d   = upd_q;
    qt_d    = qt_q;
    qt_nx   = qt_q;
    vld_d   = 1'b0;
    lol_d   = 1'b0;
    if (!en) begin
      st_d    = S_IDLE;
      integ_d = '0;
      ph_d    = '0;
      win_d   = '0;
      upd_d   = '0;
      qt_d    = '0;
    end else if (st_q == S_IDLE) begin
      st_d = S_ACQ;
      ph_d = '0;
    end else begin
      integ_d = stepped ? '0 : sum;
      vld_d   = stepped;
      if (step_up) code_d = code_q + stp_sz;
      else if (step_dn) code_d = code_q - stp_sz;
      case (st_q)
        S_ACQ: begin
          if (ph_q == PW'(ACQ_CYCLES - 1)) begin
            st_d  = S_TRACK;
            win_d = '0;
            upd_d = '0;
            qt_d  = '0;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
        default: begin
          if (win_end) begin
            win_d = '0;
            upd_d = '0;
            if (st_q == S_TRACK) begin
              qt_nx = (upd_tot <= UW'(LOCK_MAX_UPD)) ? qt_q + 1'b1 : '0;
              qt_d  = qt_nx;
              if (qt_nx == QW'(LOCK_CNT)) st_d = S_LOCK;
            end else if (upd_tot > UW'(UNLOCK_UPD)) begin
              st_d    = S_ACQ;
              lol_d   = 1'b1;
              integ_d = '0;
              ph_d    = '0;
            end
          end else begin
            win_d = win_q + 1'b1;
            upd_d = upd_tot;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= S_IDLE;
      integ_q     <= '0;
      code_q      <= '0;
      ph_q        <= '0;
      win_q       <= '0;
      upd_q       <= '0;
      qt_q        <= '0;
      pi_code     <= '0;
      pi_code_vld <= 1'b0;
      locked      <= 1'b0;
      lol         <= 1'b0;
    end else begin
      st_q        <= st_d;
      integ_q     <= integ_d;
      code_q      <= code_d;
      ph_q        <= ph_d;
      win_q       <= win_d;
      upd_q       <= upd_d;
      qt_q        <= qt_d;
`ifdef CDR_PI_GRAY_OUT_EN
      pi_code     <= code_d ^ (code_d >> 1);
`else
      pi_code     <= code_d;
`endif
      pi_code_vld <= vld_d;
      locked      <= (st_d == S_LOCK);
      lol         <= lol_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_cdr_pi_ctrl.sv
// Randomized and directed bench for cdr_pi_ctrl against an integer-level model.
// Honors CDR_PI_GRAY_OUT_EN for the expected pi_code encoding.
module tb_cdr_pi_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       up  = 1'b0;
  logic       dn  = 1'b0;
  logic [5:0] pi_code;
  logic       pi_code_vld;
  logic       locked;
  logic       lol;
  logic [1:0] state;

  cdr_pi_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .dn(dn),
    .pi_code(pi_code), .pi_code_vld(pi_code_vld),
    .locked(locked), .lol(lol), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: 0 idle, 1 acquire, 2 track, 3 locked
  int m_st, m_int, m_code, m_ph, m_win, m_upd, m_quiet;
  int m_vld, m_lol;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int enc(int c);
`ifdef CDR_PI_GRAY_OUT_EN
    return c ^ (c >> 1);
`else
    return c;
`endif
  endfunction

  task automatic model_reset();
    m_st = 0; m_int = 0; m_code = 0; m_ph = 0;
    m_win = 0; m_upd = 0; m_quiet = 0; m_vld = 0; m_lol = 0;
  endtask

  task automatic model_step(bit e, bit u, bit d);
    int v, nx, sz, stp, tot;
    v = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
    m_vld = 0;
    m_lol = 0;
    if (!e) begin
      m_st = 0; m_int = 0; m_ph = 0;
      m_win = 0; m_upd = 0; m_quiet = 0;
      return;
    end
    if (m_st == 0) begin
      m_st = 1;
      m_ph = 0;
      return;
    end
    sz  = (m_st == 1) ? 4 : 1;
    nx  = m_int + v;
    stp = 0;
    if (nx >= 8) begin
      m_code = (m_code + sz) % 64; nx = 0; stp = 1;
    end else if (nx <= -8) begin
      m_code = (m_code - sz + 64) % 64; nx = 0; stp = 1;
    end
    m_int = nx;
    m_vld = stp;
    if (m_st == 1) begin
      if (m_ph == 255) begin
        m_st = 2; m_win = 0; m_upd = 0; m_quiet = 0;
      end else begin
        m_ph++;
      end
    end else begin
      tot = m_upd + stp;
      if (tot > 127) tot = 127;
      if (m_win == 63) begin
        m_win = 0;
        m_upd = 0;
        if (m_st == 2) begin
          m_quiet = (tot <= 2) ? m_quiet + 1 : 0;
          if (m_quiet == 4) m_st = 3;
        end else if (tot > 6) begin
          m_st = 1; m_lol = 1; m_int = 0; m_ph = 0;
        end
      end else begin
        m_win++;
        m_upd = tot;
      end
    end
  endtask

  task automatic compare_all();
    chk("pi_code", 32'(pi_code), 32'(enc(m_code)));
    chk("pi_code_vld", 32'(pi_code_vld), 32'(m_vld));
    chk("locked", 32'(locked), 32'(m_st == 3));
    chk("lol", 32'(lol), 32'(m_lol));
    chk("state", 32'(state), 32'(m_st));
  endtask

  task automatic cyc(bit e, bit u, bit d);
    en = e; up = u; dn = d;
    model_step(e, u, d);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #4;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    chk("rst_now_code", 32'(pi_code), 32'd0);
    chk("rst_now_state", 32'(state), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    rst = 1'b0;
  endtask

  initial begin
    int c0, k, mode;
    bit e, u, d;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("reset_code", 32'(pi_code), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    rst = 1'b0;

    cyc(1, 0, 0);
    chk("enter_acq", 32'(state), 32'd1);
    repeat (8) cyc(1, 1, 0);
    chk("acq_first_step", 32'(pi_code), 32'(enc(4)));
    chk("acq_first_vld", 32'(pi_code_vld), 32'd1);
    cyc(1, 1, 0);
    chk("vld_one_cycle", 32'(pi_code_vld), 32'd0);
    repeat (7) cyc(1, 1, 0);
    chk("acq_second_step", 32'(pi_code), 32'(enc(8)));
    repeat (104) cyc(1, 1, 0);
    chk("acq_at_60", 32'(pi_code), 32'(enc(60)));
    repeat (8) cyc(1, 1, 0);
    chk("acq_wrap", 32'(pi_code), 32'(enc(0)));
    repeat (128) cyc(1, 1, 0);
    chk("to_track", 32'(state), 32'd2);
    chk("edge_step_acq", 32'(pi_code), 32'(enc(0)));

    repeat (16) cyc(1, 1, 0);
    chk("track_step1", 32'(pi_code), 32'(enc(2)));
    for (int i = 0; i < 300 && m_st != 3; i++)
      cyc(1, (i % 2) == 0, (i % 2) == 1);
    chk("locked_set", 32'(locked), 32'd1);
    chk("quiet_hold", 32'(pi_code), 32'(enc(2)));
    repeat (100) cyc(1, 1, 1);
    chk("both_ignored", 32'(pi_code), 32'(enc(2)));
    chk("still_locked", 32'(locked), 32'd1);

    k = 0;
    while (k < 200 && m_lol == 0) begin
      cyc(1, 1, 0);
      k++;
    end
    chk("lol_pulse", 32'(lol), 32'd1);
    chk("lol_unlock", 32'(locked), 32'd0);
    chk("lol_state", 32'(state), 32'd1);
    c0 = m_code;
    k = 0;
    do begin
      cyc(1, 1, 0);
      k++;
    end while (k < 20 && m_vld == 0);
    chk("reacq_step4", 32'(pi_code), 32'(enc((c0 + 4) % 64)));

    for (int i = 0; i < 300 && m_st != 2; i++)
      cyc(1, (i % 2) == 0, (i % 2) == 1);
    chk("track_again", 32'(state), 32'd2);
    for (int i = 0; i < 700 && m_code != 21; i++)
      cyc(1, 1, 0);
    chk("code_21", 32'(pi_code), 32'(enc(21)));
    cyc(0, 0, 0);
    chk("en_off_state", 32'(state), 32'd0);
    chk("en_off_code", 32'(pi_code), 32'(enc(21)));
    chk("en_off_nolol", 32'(lol), 32'd0);

    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 256) == 0) mode = $urandom_range(0, 2);
      e = ($urandom_range(0, 299) != 0);
      case (mode)
        0: begin u = $urandom_range(0, 1); d = $urandom_range(0, 1); end
        1: begin u = (i % 2) == 0; d = (i % 2) == 1; end
        default: begin
          u = ($urandom_range(0, 9) != 0);
          d = ($urandom_range(0, 9) == 0);
        end
      endcase
      cyc(e, u, d);
      if (i == 1500) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
